// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - NPORTS-way request/grant arbiter with bus lock in front of a single-port RAM
//
// Purpose: arbitrates NPORTS masters onto one synchronous single-port RAM using
// fixed-priority or round-robin selection, with a per-port lock that lets one
// master own the RAM across many accesses.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   mode_i                0 = fixed priority (port 0 highest), 1 = round-robin
//   req_i/we_i/lock_i     per-port request, write enable, lock request
//   addr_i/wdata_i        per-port address/write data, port k at [k*W +: W]
//   gnt_o                 one-cycle accept pulse (one-hot or zero)
//   rvalid_o              one-cycle read-data-valid pulse (one-hot or zero)
//   rdata_o               shared read data (pass-through of ram_data_i)
//   locked_o/owner_o      bus locked and index of the locking port
//   ram_*                 RAM macro strobe, write enable, address, data in/out
module ram_arbiter #(
  parameter int NPORTS = 3,
  parameter int AW     = 5,
  parameter int DW     = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      mode_i,
  input  logic [NPORTS-1:0]         req_i,
  input  logic [NPORTS-1:0]         we_i,
  input  logic [NPORTS-1:0]         lock_i,
  input  logic [NPORTS*AW-1:0]      addr_i,
  input  logic [NPORTS*DW-1:0]      wdata_i,
  output logic [NPORTS-1:0]         gnt_o,
  output logic [NPORTS-1:0]         rvalid_o,
  output logic [DW-1:0]             rdata_o,
  output logic                      locked_o,
  output logic [$clog2(NPORTS)-1:0] owner_o,
  output logic                      ram_en_o,
  output logic                      ram_we_o,
  output logic [AW-1:0]             ram_addr_o,
  output logic [DW-1:0]             ram_data_o,
  input  logic [DW-1:0]             ram_data_i
);

  localparam int PW = $clog2(NPORTS);

  typedef enum logic {ST_ARB, ST_LOCKED} state_t;

  state_t            r_state;
  logic [NPORTS-1:0] r_gnt;
  logic [NPORTS-1:0] r_rvalid;
  logic [PW-1:0]     r_owner;
  logic [PW-1:0]     r_rr_ptr;
  logic              r_ram_en;
  logic              r_ram_we;
  logic [AW-1:0]     r_ram_addr;
  logic [DW-1:0]     r_ram_data;

  logic [NPORTS-1:0] w_elig;
  logic [NPORTS-1:0] w_owner_mask;
  logic [NPORTS-1:0] w_cand;
  logic [NPORTS-1:0] w_win_oh;
  logic              w_leave;
  logic              w_found;
  logic [PW-1:0]     w_win;
  logic [PW-1:0]     w_pos;
  int                w_idx;

  // A port granted last cycle sits out this edge, so a late-dropping req is
  // never granted twice.
  assign w_elig       = req_i & ~r_gnt;
  assign w_owner_mask = {{(NPORTS-1){1'b0}}, 1'b1} << r_owner;
  assign w_leave      = (r_state == ST_LOCKED) && (!req_i[r_owner] || !lock_i[r_owner]);
  assign w_win_oh     = {{(NPORTS-1){1'b0}}, 1'b1} << w_win;

  // Candidate set: everyone in ARB; only the owner while locked. On the
  // unlocking edge the owner gets its final access if it is eligible,
  // otherwise the edge falls back to ordinary arbitration.
  always_comb begin
    w_cand = '0;
    if (r_state == ST_ARB) begin
      w_cand = w_elig;
    end else if (|(w_elig & w_owner_mask)) begin
      w_cand = w_elig & w_owner_mask;
    end else if (w_leave) begin
      w_cand = w_elig;
    end
  end

  // Search order is 0..NPORTS-1 in fixed mode, or starts at rr_ptr and wraps.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    w_pos   = '0;
    for (int i = 0; i < NPORTS; i++) begin
      w_idx = mode_i ? (int'(r_rr_ptr) + i) % NPORTS : i;
      w_pos = PW'(w_idx);
      if (!w_found && w_cand[w_pos]) begin
        w_found = 1'b1;
        w_win   = w_pos;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_ARB;
      r_gnt      <= '0;
      r_rvalid   <= '0;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_ram_en   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
    end else begin
      // The RAM samples the current strobe at this edge; its read data shows
      // up next cycle, tagged with the port that was granted.
      r_rvalid <= (r_ram_en && !r_ram_we) ? r_gnt : '0;
      r_ram_en <= w_found;
      if (w_found) begin
        r_gnt      <= w_win_oh;
        r_ram_we   <= we_i[w_win];
        r_ram_addr <= addr_i[w_win*AW +: AW];
        r_ram_data <= wdata_i[w_win*DW +: DW];
        r_rr_ptr   <= (w_win == PW'(NPORTS-1)) ? '0 : w_win + 1'b1;
        if (lock_i[w_win]) begin
          r_state <= ST_LOCKED;
          r_owner <= w_win;
        end else begin
          r_state <= ST_ARB;
        end
      end else begin
        r_gnt    <= '0;
        r_ram_we <= 1'b0;
        if (w_leave) begin
          r_state <= ST_ARB;
        end
      end
    end
  end

  assign gnt_o      = r_gnt;
  assign rvalid_o   = r_rvalid;
  assign rdata_o    = ram_data_i;
  assign locked_o   = (r_state == ST_LOCKED);
  assign owner_o    = r_owner;
  assign ram_en_o   = r_ram_en;
  assign ram_we_o   = r_ram_we;
  assign ram_addr_o = r_ram_addr;
  assign ram_data_o = r_ram_data;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with a behavioural reference model
module tb_ram_arbiter;

  localparam int NP = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic              clk;
  logic              rst;
  logic              mode;
  logic [NP-1:0]     req;
  logic [NP-1:0]     we;
  logic [NP-1:0]     lock;
  logic [NP*AW-1:0]  addr;
  logic [NP*DW-1:0]  wdata;
  logic [NP-1:0]     gnt;
  logic [NP-1:0]     rvalid;
  logic [DW-1:0]     rdata;
  logic              locked;
  logic [1:0]        owner;
  logic              ram_en;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_wdata;
  logic [DW-1:0]     ram_rdata;

  int n_checks;
  int n_fail;

  ram_arbiter #(.NPORTS(NP), .AW(AW), .DW(DW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .mode_i     (mode),
    .req_i      (req),
    .we_i       (we),
    .lock_i     (lock),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .gnt_o      (gnt),
    .rvalid_o   (rvalid),
    .rdata_o    (rdata),
    .locked_o   (locked),
    .owner_o    (owner),
    .ram_en_o   (ram_en),
    .ram_we_o   (ram_we),
    .ram_addr_o (ram_addr),
    .ram_data_o (ram_wdata),
    .ram_data_i (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM macro stand-in
  logic [DW-1:0] tb_ram [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) tb_ram[i] <= '0;
    end else if (ram_en) begin
      if (ram_we) tb_ram[ram_addr] <= ram_wdata;
      else        ram_rdata <= tb_ram[ram_addr];
    end
  end

  // Reference model state: what the outputs must be after each edge
  logic [NP-1:0] m_gnt, m_rvalid;
  bit            m_locked;
  int            m_owner, m_rr;
  bit            m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_rdata;
  logic [DW-1:0] m_mem [32];

  task automatic model_edge();
    int order[$];
    int win;
    bit leave;
    bit allow_all;
    bit owner_only;
    logic [NP-1:0] elig;
    if (rst) begin
      m_gnt = '0; m_rvalid = '0; m_locked = 0; m_owner = 0; m_rr = 0;
      m_en = 0; m_we = 0; m_addr = '0; m_data = '0;
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      return;
    end
    m_rvalid = (m_en && !m_we) ? m_gnt : '0;
    if (m_en) begin
      if (m_we) m_mem[m_addr] = m_data;
      else      m_rdata = m_mem[m_addr];
    end
    elig  = req & ~m_gnt;
    leave = m_locked && (!req[m_owner] || !lock[m_owner]);
    owner_only = m_locked && elig[m_owner];
    allow_all  = !m_locked || (leave && !elig[m_owner]);
    for (int n = 0; n < NP; n++) order.push_back(mode ? (m_rr + n) % NP : n);
    win = -1;
    foreach (order[j]) begin
      if (win < 0 && elig[order[j]] && (allow_all || (owner_only && order[j] == m_owner)))
        win = order[j];
    end
    if (win >= 0) begin
      m_gnt  = '0;
      m_gnt[win] = 1'b1;
      m_en   = 1;
      m_we   = we[win];
      m_addr = addr[win*AW +: AW];
      m_data = wdata[win*DW +: DW];
      m_rr   = (win + 1) % NP;
      m_locked = lock[win];
      if (lock[win]) m_owner = win;
    end else begin
      m_gnt = '0;
      m_en  = 0;
      m_we  = 0;
      if (leave) m_locked = 0;
    end
  endtask

  // Inputs are applied at the falling edge; outputs are sampled at the next one.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; idle_inputs();
    cycle(); cycle();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      n_checks++;
      if ({gnt, rvalid, locked, owner, ram_en, ram_we} !== '0) begin
        n_fail++;
        $display("FAIL reset_ctrl: got gnt=%b rvalid=%b locked=%b owner=%0d en=%b we=%b required all 0",
                 gnt, rvalid, locked, owner, ram_en, ram_we);
      end
      n_checks++;
      if (ram_addr !== '0 || ram_wdata !== '0) begin
        n_fail++;
        $display("FAIL reset_bus: got addr=%h data=%h required 0/0", ram_addr, ram_wdata);
      end
    end
  endtask

  task automatic test_write_read();
    mode = 1'b0; idle_inputs();
    req = 3'b010; we = 3'b010;
    addr[AW +: AW] = 5'h0A; wdata[DW +: DW] = 32'hDEADBEEF;
    cycle();
    n_checks++;
    if (gnt !== 3'b010 || ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 5'h0A || ram_wdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL wr_grant: got gnt=%b en=%b we=%b addr=%h data=%h required 010/1/1/0a/deadbeef",
               gnt, ram_en, ram_we, ram_addr, ram_wdata);
    end
    req = '0; we = '0;
    cycle();
    n_checks++;
    if (gnt !== 3'b000 || ram_en !== 1'b0 || rvalid !== 3'b000) begin
      n_fail++;
      $display("FAIL wr_after: got gnt=%b en=%b rvalid=%b required 000/0/000", gnt, ram_en, rvalid);
    end
    req = 3'b010;
    cycle();
    n_checks++;
    if (gnt !== 3'b010 || ram_en !== 1'b1 || ram_we !== 1'b0 || rvalid !== 3'b000) begin
      n_fail++;
      $display("FAIL rd_grant: got gnt=%b en=%b we=%b rvalid=%b required 010/1/0/000", gnt, ram_en, ram_we, rvalid);
    end
    req = '0;
    cycle();
    n_checks++;
    if (rvalid !== 3'b010 || rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL rd_data: got rvalid=%b rdata=%h required 010/deadbeef", rvalid, rdata);
    end
    cycle();
    n_checks++;
    if (rvalid !== 3'b000) begin
      n_fail++;
      $display("FAIL rd_pulse: got rvalid=%b required 000", rvalid);
    end
  endtask

  task automatic test_fixed_priority();
    mode = 1'b0; idle_inputs();
    cycle();
    req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      cycle();
      n_checks++;
      if (gnt !== ((i % 2 == 0) ? 3'b001 : 3'b010)) begin
        n_fail++;
        $display("FAIL fixed_seq[%0d]: got gnt=%b required %b", i, gnt, (i % 2 == 0) ? 3'b001 : 3'b010);
      end
    end
    req = '0;
    cycle();
  endtask

  task automatic test_round_robin();
    rst = 1'b1; idle_inputs();
    cycle();
    rst = 1'b0; mode = 1'b1; req = 3'b111;
    for (int i = 0; i < 7; i++) begin
      cycle();
      n_checks++;
      if (gnt !== (3'b001 << (i % 3))) begin
        n_fail++;
        $display("FAIL rr_seq[%0d]: got gnt=%b required %b", i, gnt, 3'b001 << (i % 3));
      end
    end
    req = '0; mode = 1'b0;
    cycle();
  endtask

  task automatic test_lock();
    rst = 1'b1; idle_inputs();
    cycle();
    rst = 1'b0; mode = 1'b0;
    req = 3'b100; lock = 3'b100;
    cycle();
    n_checks++;
    if (gnt !== 3'b100 || locked !== 1'b1 || owner !== 2'd2) begin
      n_fail++;
      $display("FAIL lock_take: got gnt=%b locked=%b owner=%0d required 100/1/2", gnt, locked, owner);
    end
    req = 3'b111;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_checks++;
      if (gnt !== ((i % 2 == 0) ? 3'b000 : 3'b100) || locked !== 1'b1 || owner !== 2'd2) begin
        n_fail++;
        $display("FAIL lock_hold[%0d]: got gnt=%b locked=%b owner=%0d required %b/1/2",
                 i, gnt, locked, owner, (i % 2 == 0) ? 3'b000 : 3'b100);
      end
    end
    lock = 3'b000;
    cycle();
    n_checks++;
    if (gnt !== 3'b100 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_release: got gnt=%b locked=%b required 100/0", gnt, locked);
    end
    cycle();
    n_checks++;
    if (gnt !== 3'b001) begin
      n_fail++;
      $display("FAIL lock_resume: got gnt=%b required 001", gnt);
    end
    req = '0;
    cycle();
  endtask

  task automatic test_reset_mid_access();
    idle_inputs(); mode = 1'b0;
    cycle();
    req = 3'b001; lock = 3'b001;
    cycle();
    n_checks++;
    if (gnt !== 3'b001 || ram_en !== 1'b1 || ram_we !== 1'b0 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_setup: got gnt=%b en=%b we=%b locked=%b required 001/1/0/1", gnt, ram_en, ram_we, locked);
    end
    rst = 1'b1; req = '0; lock = '0;
    cycle();
    n_checks++;
    if (rvalid !== 3'b000 || locked !== 1'b0 || ram_en !== 1'b0 || gnt !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_drop: got rvalid=%b locked=%b en=%b gnt=%b required 000/0/0/000", rvalid, locked, ram_en, gnt);
    end
    rst = 1'b0;
    cycle();
    n_checks++;
    if (rvalid !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_after: got rvalid=%b required 000", rvalid);
    end
  endtask

  task automatic test_random();
    rst = 1'b1; idle_inputs();
    cycle();
    rst = 1'b0;
    for (int c = 0; c < 800; c++) begin
      rst  = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      req  = NP'($urandom);
      we   = NP'($urandom);
      lock = ($urandom_range(0, 2) == 0) ? NP'($urandom) : '0;
      for (int p = 0; p < NP; p++) addr[p*AW +: AW] = AW'($urandom_range(0, 7));
      wdata = {$urandom, $urandom, $urandom};
      cycle();
      n_checks++;
      if (gnt !== m_gnt || rvalid !== m_rvalid) begin
        n_fail++;
        $display("FAIL rnd_gnt[%0d]: got gnt=%b rvalid=%b required %b/%b", c, gnt, rvalid, m_gnt, m_rvalid);
      end
      n_checks++;
      if (locked !== m_locked || owner !== 2'(m_owner)) begin
        n_fail++;
        $display("FAIL rnd_lock[%0d]: got locked=%b owner=%0d required %b/%0d", c, locked, owner, m_locked, m_owner);
      end
      n_checks++;
      if (ram_en !== m_en || ram_we !== m_we || ram_addr !== m_addr || ram_wdata !== m_data) begin
        n_fail++;
        $display("FAIL rnd_ram[%0d]: got en=%b we=%b addr=%h data=%h required %b/%b/%h/%h",
                 c, ram_en, ram_we, ram_addr, ram_wdata, m_en, m_we, m_addr, m_data);
      end
      if (m_rvalid != '0) begin
        n_checks++;
        if (rdata !== m_rdata) begin
          n_fail++;
          $display("FAIL rnd_rdata[%0d]: got %h required %h", c, rdata, m_rdata);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; mode = 1'b0;
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    test_reset();
    test_write_read();
    test_fixed_priority();
    test_round_robin();
    test_lock();
    test_reset_mid_access();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Parametrised single-clock successor to the three-way RAM plexer. It arbitrates NPORTS requesters (processor core, SPI loader, Wishbone config, and any future masters) onto one synchronous single-port RAM. Arbitration uses a request/grant handshake, selectable fixed-priority or round-robin policy, and a per-port bus lock that lets one master own the RAM across many accesses, replacing the old halt/cs takeover combinations. It sits between the masters and the RAM macro in the user area.

## Interface
Parameters:
- NPORTS, 3, number of requesting ports (2..8); port 0 is highest fixed priority
- AW, 5, address width
- DW, 32, data width

Ports:
- clk_i  in  1  single clock; all logic rising-edge
- rst_i  in  1  reset; synchronous, active-high
- mode_i  in  1  0 = fixed priority, 1 = round-robin
- req_i  in  NPORTS  per-port access request
- we_i  in  NPORTS  per-port write enable, qualified by req_i
- lock_i  in  NPORTS  per-port lock request, qualified by req_i
- addr_i  in  NPORTS*AW  port k at [k*AW +: AW]
- wdata_i  in  NPORTS*DW  port k at [k*DW +: DW]
- gnt_o  out  NPORTS  one-cycle accept pulse, one-hot or zero
- rvalid_o  out  NPORTS  one-cycle read-data-valid pulse, one-hot or zero
- rdata_o  out  DW  shared read data, equal to ram_data_i
- locked_o  out  1  bus is locked
- owner_o  out  $clog2(NPORTS)  locking port index, valid while locked_o
- ram_en_o  out  1  RAM access strobe
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  AW  RAM address
- ram_data_o  out  DW  RAM write data
- ram_data_i  in  DW  RAM read data, valid one cycle after a read strobe

## Operation
- FSM states: ARB and LOCKED. Reset enters ARB.
- **Eligible set at each edge:** req_i AND NOT gnt_o. A port is ineligible in the cycle its gnt_o is high, so a master that holds req one cycle late is never double-granted.
- **ARB, fixed priority:** the lowest-index eligible port wins.
- **ARB, round-robin:** search starts at rr_ptr and wraps from NPORTS-1 to 0. The first eligible port wins.
- **Pointer update:** on every grant to port k, rr_ptr becomes (k+1) mod NPORTS. This happens in both modes. A mode_i change takes effect at the next arbitration edge.
- **Issuing an access:** on a grant to k, the block registers ram_en_o=1, ram_we_o=we_i[k], ram_addr_o=addr_i[k], and ram_data_o=wdata_i[k]. It asserts gnt_o[k] for one cycle.
- **No winner:** ram_en_o=0 and ram_we_o=0. Address and data hold their last values.
- **Entering LOCKED:** if the winner k has lock_i[k]=1, the next state is LOCKED with owner_o=k.
- **LOCKED:** only port owner_o can be granted, and it can be granted every other cycle per the eligibility rule. All other requests stall.
- **Leaving LOCKED:** the FSM returns to ARB at the first edge where req_i[owner] is high with lock_i[owner]=0, or where req_i[owner] is low. That same edge is a normal arbitration edge; in the req-with-lock-clear case the owner's request is granted as its final locked-path access.
- **Read data:** for a read granted to k, rvalid_o[k] pulses in the cycle after the RAM strobe. rdata_o is valid only in that cycle. Writes never produce rvalid.

## Timing
- **Reset values:** gnt_o=0, rvalid_o=0, locked_o=0, owner_o=0, ram_en_o=0, ram_we_o=0, ram_addr_o=0, ram_data_o=0, rr_ptr=0.
- **Grant latency:** req high at edge E0 gives gnt_o and the RAM strobe in the cycle after E0.
- **Read latency:** the RAM samples at E1 and rvalid_o rises after E1. Read latency is 2 cycles from the request-sampling edge.
- **Throughput:** at most one RAM access per cycle. Different ports can be granted on consecutive cycles. One port gets at most one grant every 2 cycles.
- **Reset mid-access:** an rvalid pending from the cycle before reset is discarded. A lock is dropped immediately.
- **Simultaneous events:** all ports requesting in round-robin are granted in rotation 0,1,2,0... A lock request coincident with a higher-priority non-lock request follows the normal policy; the lock is taken only if the locking port wins.
- **Eligibility change:** a port whose req_i drops before the edge is simply not eligible. A request is never retained across edges.

## Test plan
- Reset check: assert rst_i, then release with no requests → every output holds its reset value; ram_en_o stays 0.
- Single write then read on port 1 (addr 5'h0A, data 32'hDEADBEEF) → gnt_o=3'b010 one cycle after each request. The read gives rvalid_o=3'b010 two cycles after the request, with rdata_o=32'hDEADBEEF.
- Fixed priority, req_i=3'b111 held continuously → grant sequence 001,010,001,010… Port 2 is starved.
- Round-robin, req_i=3'b111 held continuously → grants 001,010,100,001 on consecutive cycles; rr_ptr wraps from 2 to 0.
- Lock: port 2 requests with lock_i set and gets granted; ports 0 and 1 then request → only port 2 is granted (every other cycle), with locked_o=1 and owner_o=2. Port 2 then clears lock_i → arbitration resumes and port 0 is granted next in fixed mode.
- Reset asserted in the cycle a read is strobed → no rvalid_o pulse follows, and locked_o=0.
